// File: rtl/dram_pkg.sv
// Shared types and default sizing for the DRAM model.
package dram_pkg;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_LATENCY   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/dram_array.sv
// Single-port storage: synchronous write, registered read, no reset.
module dram_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IW     = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/dram.sv
// Fixed-latency DRAM model with IDLE/ACCESS/DONE handshake.
// Define DRAM_ADDR_CHECK_EN to flag addresses >= MEM_DEPTH via err.
module dram
  import dram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);
  localparam logic [CW-1:0] PRE  = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q;
  logic [IW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rdata;
  logic [IW-1:0]     arr_addr;
  logic              accept, exec, pre, we, oor_q, oor;

  assign accept = (state_q == IDLE) && (read || write);
  assign exec   = (state_q == ACCESS) && (cnt_q == LAST);

`ifdef DRAM_ADDR_CHECK_EN
  logic err_q;
  assign oor = {1'b0, addr} >= (ADDR_W+1)'(MEM_DEPTH);
  assign err = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= exec && oor_q;
  end
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign oor = 1'b0;
  assign err = 1'b0;
`endif

  // Array read is registered, so fetch one edge ahead of execution.
  always_comb begin
    if (LATENCY == 1) pre = accept && !write;
    else pre = (state_q == ACCESS) && (cnt_q == PRE) && !wr_q;
  end

  assign we       = exec && wr_q && !oor_q;
  assign arr_addr = (state_q == IDLE) ? addr[IW-1:0] : addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (cnt_q == LAST) state_d = DONE;
        else cnt_d = cnt_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= write;
        addr_q  <= addr[IW-1:0];
        wdata_q <= data_in;
        oor_q   <= oor;
      end
      if (exec && !wr_q) dout_q <= oor_q ? '0 : rdata;
    end
  end

  dram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IW     (IW)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .re_i    (pre),
    .addr_i  (arr_addr),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  assign data_out = dout_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
endmodule

// File: tb/tb_dram.sv
// Directed bench for dram: timing, read/write, collisions, reset, aliasing.
module tb_dram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram #(
    .ADDR_W    (16),
    .DATA_W    (8),
    .MEM_DEPTH (256),
    .LATENCY   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait (bounded) for done, return to IDLE.
  task automatic op(input logic r, input logic w, input logic [15:0] a,
                    input logic [7:0] d, output int lat, output logic e);
    read = r; write = w; addr = a; data_in = d;
    tick();
    read = 1'b0; write = 1'b0;
    lat = -1;
    e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        e = err;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, err, data_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {busy, done, err, data_out});
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_timing();
    logic [1:0] exp_bd [5];
    exp_bd[0] = 2'b10; exp_bd[1] = 2'b10; exp_bd[2] = 2'b10;
    exp_bd[3] = 2'b11; exp_bd[4] = 2'b00;
    read = 1'b0; write = 1'b1; addr = 16'd10; data_in = 8'd50;
    for (int i = 0; i < 5; i++) begin
      tick();
      write = 1'b0;
      checks++;
      if ({busy, done} !== exp_bd[i]) begin
        errors++;
        $display("FAIL wr_timing edge%0d busy,done got %b exp %b",
                 i, {busy, done}, exp_bd[i]);
      end
    end
  endtask

  task automatic test_read();
    int lat;
    logic e;
    op(1'b1, 1'b0, 16'd10, 8'h00, lat, e);
    checks++;
    if (lat !== 3 || data_out !== 8'd50) begin
      errors++;
      $display("FAIL read10 lat %0d data %0d exp 3 50", lat, data_out);
    end
    op(1'b0, 1'b1, 16'd11, 8'd43, lat, e);
    op(1'b1, 1'b0, 16'd11, 8'h00, lat, e);
    checks++;
    if (data_out !== 8'd43) begin
      errors++;
      $display("FAIL read11 got %0d exp 43", data_out);
    end
    repeat (5) tick();
    checks++;
    if (data_out !== 8'd43 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold11 data %0d busy %b exp 43 0", data_out, busy);
    end
  endtask

  task automatic test_rw_both();
    int lat;
    logic e;
    op(1'b1, 1'b1, 16'd5, 8'hAA, lat, e);
    checks++;
    if (lat !== 3 || data_out !== 8'd43) begin
      errors++;
      $display("FAIL rw_both lat %0d data %h exp 3 2b", lat, data_out);
    end
    op(1'b1, 1'b0, 16'd5, 8'h00, lat, e);
    checks++;
    if (data_out !== 8'hAA) begin
      errors++;
      $display("FAIL rw_read5 got %h exp aa", data_out);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, ndone;
    logic e;
    op(1'b0, 1'b1, 16'd31, 8'h00, lat, e);
    read = 1'b0; write = 1'b1; addr = 16'd30; data_in = 8'h22;
    tick();
    write = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        write = 1'b1; addr = 16'd31; data_in = 8'h99;
      end
      tick();
      write = 1'b0;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_dones got %0d exp 1", ndone);
    end
    op(1'b1, 1'b0, 16'd31, 8'h00, lat, e);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL ignore_mem31 got %h exp 00", data_out);
    end
    op(1'b1, 1'b0, 16'd30, 8'h00, lat, e);
    checks++;
    if (data_out !== 8'h22) begin
      errors++;
      $display("FAIL ignore_mem30 got %h exp 22", data_out);
    end
  endtask

  task automatic test_back_to_back();
    int hits [$];
    read = 1'b1; addr = 16'd10;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) hits.push_back(i);
    end
    read = 1'b0;
    tick();
    checks++;
    if (hits.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 3", hits.size());
    end else begin
      checks++;
      if (hits[0] !== 3 || hits[1] !== 8 || hits[2] !== 13) begin
        errors++;
        $display("FAIL b2b_spacing got %0d %0d %0d exp 3 8 13",
                 hits[0], hits[1], hits[2]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic e;
    op(1'b0, 1'b1, 16'd20, 8'h00, lat, e);
    op(1'b1, 1'b0, 16'd5, 8'h00, lat, e);
    write = 1'b1; addr = 16'd20; data_in = 8'h77;
    tick();
    write = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, data_out} !== 11'd0) begin
      errors++;
      $display("FAIL abort_outputs got %b exp 0", {busy, done, err, data_out});
    end
    tick();
    #2 rst = 1'b0;
    tick();
    op(1'b1, 1'b0, 16'd20, 8'h00, lat, e);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL abort_mem20 got %h exp 00", data_out);
    end
  endtask

  task automatic test_addr_range();
    int lat;
    logic e;
    op(1'b0, 1'b1, 16'd44, 8'h5C, lat, e);
    op(1'b1, 1'b0, 16'd300, 8'h00, lat, e);
    checks++;
`ifdef DRAM_ADDR_CHECK_EN
    if (lat !== 3 || e !== 1'b1 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL oor_check lat %0d err %b data %h exp 3 1 00",
               lat, e, data_out);
    end
`else
    if (lat !== 3 || e !== 1'b0 || data_out !== 8'h5C) begin
      errors++;
      $display("FAIL oor_alias lat %0d err %b data %h exp 3 0 5c",
               lat, e, data_out);
    end
`endif
    op(1'b1, 1'b0, 16'd44, 8'h00, lat, e);
    checks++;
    if (e !== 1'b0 || data_out !== 8'h5C) begin
      errors++;
      $display("FAIL inrange44 err %b data %h exp 0 5c", e, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_read();
    test_rw_both();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_addr_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
